// File: rtl/branch_pkg.sv
// ============================================================================
// Module   : branch_pkg
// Brief    : Branch opcode encoding and default sizing for the branch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BRZ  = 3'd1,
      BR_BRN  = 3'd2,
      BR_JREL = 3'd3,
      BR_JABS = 3'd4,
      BR_CALL = 3'd5,
      BR_RET  = 3'd6,
      BR_LOOP = 3'd7
   } br_op_t;

   localparam int RAS_N_DEF = 4;
   localparam int LW_DEF    = 8;

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// ============================================================================
// Module   : ret_stack
// Brief    : Circular return-address stack; a push while full overwrites the oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_stack #(
   parameter int D     = 12,
   parameter int RAS_N = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [D-1:0]             push_data,
   output logic [D-1:0]             top,
   output logic [$clog2(RAS_N):0]   depth,
   output logic                     full,
   output logic                     empty
);

   localparam int                 c_ptr_w      = $clog2(RAS_N);
   localparam logic [c_ptr_w:0]   c_depth_full = (c_ptr_w + 1)'(RAS_N);

   logic [D-1:0]         r_mem [RAS_N];
   logic [c_ptr_w-1:0]   r_ptr;
   logic [c_ptr_w:0]     r_depth;
   logic [c_ptr_w-1:0]   w_ptr_inc;

   assign w_ptr_inc = r_ptr + 1'b1;
   assign full      = (r_depth == c_depth_full);
   assign empty     = (r_depth == '0);
   assign depth     = r_depth;
   assign top       = r_mem[r_ptr];

   // The pointer wraps naturally, so a push on a full stack lands on the oldest slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= '0;
         r_depth <= '0;
      end else if (push) begin
         r_ptr <= w_ptr_inc;
         if (!full)
            r_depth <= r_depth + 1'b1;
      end else if (pop && !empty) begin
         r_ptr   <= r_ptr - 1'b1;
         r_depth <= r_depth - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push)
         r_mem[w_ptr_inc] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// Module   : branch_ctrl
// Brief    : Branch decode feeding the PC: flags, loop counter, return stack, zero-latency redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl
   import branch_pkg::*;
#(
   parameter int D     = 12,
   parameter int RAS_N = RAS_N_DEF,
   parameter int LW    = LW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  br_op_t                   br_op,
   input  logic [D-1:0]             br_offset,
   input  logic [D-1:0]             br_target,
   input  logic [D-1:0]             prog_ctr,
   input  logic                     alu_zero,
   input  logic                     alu_neg,
   input  logic                     flag_we,
   input  logic                     lc_load,
   input  logic [LW-1:0]            lc_value,
   output logic                     reljump_en,
   output logic                     absjump_en,
   output logic [D-1:0]             target,
   output logic [$clog2(RAS_N):0]   ras_depth,
   output logic                     ras_ovf,
   output logic                     ras_unf
);

   br_op_t           w_op;
   logic             r_zero;
   logic             r_neg;
   logic [LW-1:0]    r_lc;
   logic             r_ovf;
   logic             r_unf;
   logic             w_push;
   logic             w_pop;
   logic             w_lc_dec;
   logic [D-1:0]     w_top;
   logic [D-1:0]     w_ret_addr;
   logic             w_full;
   logic             w_empty;

   assign w_op       = reset ? BR_NONE : br_op;
   assign w_ret_addr = prog_ctr + 1'b1;
   assign ras_ovf    = r_ovf;
   assign ras_unf    = r_unf;

   ret_stack #(
      .D     (D),
      .RAS_N (RAS_N)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_ret_addr),
      .top       (w_top),
      .depth     (ras_depth),
      .full      (w_full),
      .empty     (w_empty)
   );

   always_comb begin
      reljump_en = 1'b0;
      absjump_en = 1'b0;
      target     = '0;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_lc_dec   = 1'b0;
      case (w_op)
         BR_BRZ: if (r_zero) begin
            reljump_en = 1'b1;
            target     = br_offset;
         end
         BR_BRN: if (r_neg) begin
            reljump_en = 1'b1;
            target     = br_offset;
         end
         BR_JREL: begin
            reljump_en = 1'b1;
            target     = br_offset;
         end
         BR_JABS: begin
            absjump_en = 1'b1;
            target     = br_target;
         end
         BR_CALL: begin
            absjump_en = 1'b1;
            target     = br_target;
            w_push     = 1'b1;
         end
         BR_RET: begin
            w_pop = 1'b1;
            if (!w_empty) begin
               absjump_en = 1'b1;
               target     = w_top;
            end
         end
         BR_LOOP: if (r_lc != '0) begin
            reljump_en = 1'b1;
            target     = br_offset;
            w_lc_dec   = 1'b1;
         end
         default: ;
      endcase
   end

   // Branches see the flags and counter from before this edge; a load wins over a decrement.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
         r_lc   <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         if (flag_we) begin
            r_zero <= alu_zero;
            r_neg  <= alu_neg;
         end
         if (lc_load)
            r_lc <= lc_value;
         else if (w_lc_dec)
            r_lc <= r_lc - 1'b1;
         if (w_push && w_full)
            r_ovf <= 1'b1;
         if (w_pop && w_empty)
            r_unf <= 1'b1;
      end
   end

endmodule

`default_nettype wire
